// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-master (fetch / data) arbiter in front of a single-port
//            memory, with address legality checking and a one-cycle
//            response pipeline.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int MEMSIZE      = 131072,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        if_req_valid,
    input  logic [31:0] if_req_addr,
    output logic        if_req_ready,
    output logic        if_resp_valid,
    output logic [31:0] if_resp_data,
    output logic        if_resp_err,
    input  logic        d_req_valid,
    input  logic        d_req_write,
    input  logic [31:0] d_req_addr,
    input  logic [31:0] d_req_wdata,
    input  logic [3:0]  d_req_wstrb,
    output logic        d_req_ready,
    output logic        d_resp_valid,
    output logic [31:0] d_resp_data,
    output logic        d_resp_err,
    output logic        mem_rready,
    output logic [29:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic        mem_wready,
    output logic [29:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb
);

    // Any address bit at or above log2(MEMSIZE) makes the access out of range.
    localparam logic [31:0] c_HI_MASK = ~(32'(MEMSIZE) - 32'd1);
    localparam logic [7:0]  c_LIMIT   = 8'(STARVE_LIMIT);

    function automatic logic addr_legal(input logic [31:0] a);
        return ((a & c_HI_MASK) == 32'd0) && (a[1:0] == 2'b00);
    endfunction

    logic       w_grant_i;
    logic       w_grant_d;
    logic       w_if_legal;
    logic       w_d_legal;
    logic       w_rd_ok;

    logic       r_resp_valid;
    logic       r_resp_owner_d;
    logic       r_resp_err;
    logic       r_resp_read;
    logic [7:0] r_starve_cnt;

    assign w_if_legal = addr_legal(if_req_addr);
    assign w_d_legal  = addr_legal(d_req_addr);

    // Data wins unless fetch has waited STARVE_LIMIT data grants in a row.
    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (!resetb) begin
            if (d_req_valid && !(if_req_valid && (r_starve_cnt == c_LIMIT))) begin
                w_grant_d = 1'b1;
            end else if (if_req_valid) begin
                w_grant_i = 1'b1;
            end
        end
    end

    assign if_req_ready = w_grant_i;
    assign d_req_ready  = w_grant_d;

    // Illegal requests are granted but never reach the memory.
    always_comb begin
        mem_rready = 1'b0;
        mem_raddr  = 30'd0;
        mem_wready = 1'b0;
        mem_waddr  = 30'd0;
        mem_wdata  = 32'd0;
        mem_wstrb  = 4'd0;
        if (w_grant_i && w_if_legal) begin
            mem_rready = 1'b1;
            mem_raddr  = if_req_addr[31:2];
        end else if (w_grant_d && w_d_legal) begin
            if (d_req_write) begin
                mem_wready = 1'b1;
                mem_waddr  = d_req_addr[31:2];
                mem_wdata  = d_req_wdata;
                mem_wstrb  = d_req_wstrb;
            end else begin
                mem_rready = 1'b1;
                mem_raddr  = d_req_addr[31:2];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resetb) begin
            r_resp_valid   <= 1'b0;
            r_resp_owner_d <= 1'b0;
            r_resp_err     <= 1'b0;
            r_resp_read    <= 1'b0;
            r_starve_cnt   <= 8'd0;
        end else begin
            r_resp_valid   <= w_grant_i | w_grant_d;
            r_resp_owner_d <= w_grant_d;
            r_resp_err     <= w_grant_d ? ~w_d_legal : ~w_if_legal;
            r_resp_read    <= w_grant_i | ~d_req_write;

            if (!if_req_valid || w_grant_i) begin
                r_starve_cnt <= 8'd0;
            end else if (w_grant_d && (r_starve_cnt < c_LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + 8'd1;
            end
        end
    end

    // A response pending when reset arrives is suppressed, so a read granted
    // just before reset never becomes visible to its master.
    assign w_rd_ok = r_resp_valid && !resetb && !r_resp_err && r_resp_read;

    assign if_resp_valid = r_resp_valid && !resetb && !r_resp_owner_d;
    assign if_resp_data  = (w_rd_ok && !r_resp_owner_d) ? mem_rdata : 32'd0;
    assign if_resp_err   = if_resp_valid && r_resp_err;

    assign d_resp_valid  = r_resp_valid && !resetb && r_resp_owner_d;
    assign d_resp_data   = (w_rd_ok && r_resp_owner_d) ? mem_rdata : 32'd0;
    assign d_resp_err    = d_resp_valid && r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Randomized and directed bench for mem_arbiter against a
//            behavioural model of arbitration, legality and memory contents.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int MEMSIZE      = 131072;
    localparam int STARVE_LIMIT = 4;
    localparam int WORDS        = MEMSIZE / 4;

    logic        clk = 1'b0;
    logic        resetb;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready;
    logic        if_resp_valid;
    logic [31:0] if_resp_data;
    logic        if_resp_err;
    logic        d_req_valid;
    logic        d_req_write;
    logic [31:0] d_req_addr;
    logic [31:0] d_req_wdata;
    logic [3:0]  d_req_wstrb;
    logic        d_req_ready;
    logic        d_resp_valid;
    logic [31:0] d_resp_data;
    logic        d_resp_err;
    logic        mem_rready;
    logic [29:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic        mem_wready;
    logic [29:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    mem_arbiter #(.MEMSIZE(MEMSIZE), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .resetb(resetb),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data), .if_resp_err(if_resp_err),
        .d_req_valid(d_req_valid), .d_req_write(d_req_write), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb), .d_req_ready(d_req_ready),
        .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data), .d_resp_err(d_resp_err),
        .mem_rready(mem_rready), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .mem_wready(mem_wready), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = nw[8*b +: 8];
        end
        return res;
    endfunction

    function automatic bit legal(input logic [31:0] a);
        return (a < 32'(MEMSIZE)) && (a[1:0] == 2'b00);
    endfunction

    // Memory seen by the DUT, driven only by the DUT strobes.
    logic [31:0] mem [0:WORDS-1];
    always @(posedge clk) begin
        if (mem_wready) mem[mem_waddr[14:0]] <= merge(mem[mem_waddr[14:0]], mem_wdata, mem_wstrb);
        if (mem_rready) mem_rdata <= mem[mem_raddr[14:0]];
    end

    // Reference model state
    logic [31:0] ref_mem [0:WORDS-1];
    int          starve;
    bit          p_valid, p_owner_d, p_err;
    logic [31:0] p_data;
    bit          g_i, g_d;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: inputs already applied; check at the falling edge,
    // then advance the model across the rising edge.
    task automatic cycle();
        bit          gi, gd, il, dl, er, ew;
        logic [29:0] ea;
        #4;
        gi = 0;
        gd = 0;
        if (!resetb) begin
            if (if_req_valid && d_req_valid) begin
                if (starve >= STARVE_LIMIT) gi = 1; else gd = 1;
            end else if (if_req_valid) gi = 1;
            else if (d_req_valid) gd = 1;
        end
        il = legal(if_req_addr);
        dl = legal(d_req_addr);
        er = (gi && il) || (gd && dl && !d_req_write);
        ew = gd && dl && d_req_write;
        ea = gi ? if_req_addr[31:2] : d_req_addr[31:2];

        check_val("if_req_ready", 32'(if_req_ready), 32'(gi));
        check_val("d_req_ready",  32'(d_req_ready),  32'(gd));
        check_val("mem_rready",   32'(mem_rready),   32'(er));
        check_val("mem_raddr",    32'(mem_raddr),    er ? 32'(ea) : 32'd0);
        check_val("mem_wready",   32'(mem_wready),   32'(ew));
        check_val("mem_waddr",    32'(mem_waddr),    ew ? 32'(d_req_addr[31:2]) : 32'd0);
        check_val("mem_wdata",    mem_wdata,         ew ? d_req_wdata : 32'd0);
        check_val("mem_wstrb",    32'(mem_wstrb),    ew ? 32'(d_req_wstrb) : 32'd0);

        check_val("if_resp_valid", 32'(if_resp_valid), 32'(p_valid && !p_owner_d && !resetb));
        check_val("if_resp_err",   32'(if_resp_err),   32'(p_valid && !p_owner_d && !resetb && p_err));
        check_val("if_resp_data",  if_resp_data, (p_valid && !p_owner_d && !resetb) ? p_data : 32'd0);
        check_val("d_resp_valid",  32'(d_resp_valid),  32'(p_valid && p_owner_d && !resetb));
        check_val("d_resp_err",    32'(d_resp_err),    32'(p_valid && p_owner_d && !resetb && p_err));
        check_val("d_resp_data",   d_resp_data, (p_valid && p_owner_d && !resetb) ? p_data : 32'd0);

        @(posedge clk);
        if (resetb) begin
            starve  = 0;
            p_valid = 0;
        end else begin
            p_valid   = gi || gd;
            p_owner_d = gd;
            p_err     = gd ? !dl : !il;
            p_data    = 32'd0;
            if (gi && il) p_data = ref_mem[if_req_addr[16:2]];
            if (gd && dl && !d_req_write) p_data = ref_mem[d_req_addr[16:2]];
            if (ew) ref_mem[d_req_addr[16:2]] = merge(ref_mem[d_req_addr[16:2]], d_req_wdata, d_req_wstrb);
            if (!if_req_valid || gi) starve = 0;
            else if (gd && starve < STARVE_LIMIT) starve = starve + 1;
        end
        g_i = gi;
        g_d = gd;
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 15);
        if (r == 0) return 32'h0002_0000 + 32'($urandom_range(0, 255)) * 4;
        if (r == 1) return 32'($urandom_range(0, 1023)) * 4 + 32'($urandom_range(1, 3));
        if (r == 2) return 32'h8000_0000 | ($urandom & 32'h0000_FFFC);
        if (r < 9)  return 32'($urandom_range(0, 15)) * 4;
        return 32'($urandom_range(0, WORDS - 1)) * 4;
    endfunction

    task automatic new_d_req(input bit legal_only);
        d_req_valid = 1'b1;
        d_req_write = 1'($urandom_range(0, 1));
        d_req_addr  = legal_only ? 32'($urandom_range(0, 63)) * 4 : rand_addr();
        d_req_wdata = $urandom;
        d_req_wstrb = 4'($urandom_range(0, 15));
    endtask

    logic [31:0] old_word;

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        starve  = 0;
        p_valid = 0;
        resetb       = 1'b1;
        if_req_valid = 1'b1;
        if_req_addr  = 32'h40;
        d_req_valid  = 1'b1;
        d_req_write  = 1'b0;
        d_req_addr   = 32'h80;
        d_req_wdata  = 32'd0;
        d_req_wstrb  = 4'd0;
        @(posedge clk);
        #1;

        // Reset held with both masters requesting
        for (int i = 0; i < 10; i++) cycle();

        // First fetch after reset
        resetb      = 1'b0;
        d_req_valid = 1'b0;
        if_req_addr = 32'h10;
        cycle();
        if_req_valid = 1'b0;
        cycle();

        // Contention: new legal request whenever a master is granted
        if_req_valid = 1'b1;
        if_req_addr  = 32'h0;
        new_d_req(1'b1);
        for (int i = 0; i < 22; i++) begin
            cycle();
            if (g_i) if_req_addr = 32'($urandom_range(0, 63)) * 4;
            if (g_d) new_d_req(1'b1);
        end

        // Partial write followed immediately by a read of the same word
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        cycle();
        old_word    = ref_mem[64];
        d_req_valid = 1'b1;
        d_req_write = 1'b1;
        d_req_addr  = 32'h100;
        d_req_wdata = 32'hDEAD_BEEF;
        d_req_wstrb = 4'b0011;
        cycle();
        d_req_write = 1'b0;
        cycle();
        d_req_valid = 1'b0;
        check_val("fwd_data", d_resp_data, {old_word[31:16], 16'hBEEF});
        check_val("fwd_err", 32'(d_resp_err), 32'd0);
        cycle();

        // Illegal addresses: out of range fetch, misaligned data read
        if_req_valid = 1'b1;
        if_req_addr  = 32'h0002_0000;
        cycle();
        if_req_valid = 1'b0;
        d_req_valid  = 1'b1;
        d_req_write  = 1'b0;
        d_req_addr   = 32'h6;
        cycle();
        d_req_addr   = 32'h8;
        cycle();
        d_req_valid  = 1'b0;
        cycle();

        // Reset in the cycle after a data-read grant, with starvation count raised
        if_req_valid = 1'b1;
        if_req_addr  = 32'h20;
        d_req_valid  = 1'b1;
        d_req_write  = 1'b0;
        d_req_addr   = 32'h24;
        cycle();
        cycle();
        resetb = 1'b1;
        cycle();
        resetb = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        d_req_valid = 1'b0;

        // Fetch stream, data idle
        for (int k = 0; k < 8; k++) begin
            if_req_addr = 32'h200 + 32'(k) * 4;
            cycle();
        end
        if_req_valid = 1'b0;
        cycle();

        // Random traffic; a request is held until it is granted
        for (int i = 0; i < 400; i++) begin
            if (!if_req_valid || g_i) begin
                if_req_valid = ($urandom_range(0, 2) != 0);
                if_req_addr  = rand_addr();
            end
            if (!d_req_valid || g_d) begin
                if ($urandom_range(0, 2) != 0) new_d_req(1'b0);
                else d_req_valid = 1'b0;
            end
            resetb = ($urandom_range(0, 39) == 0);
            cycle();
        end
        resetb       = 1'b0;
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        cycle();
        cycle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
